// File: rtl/mem_preload_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_preload_ctrl_pkg
// Brief    : Shared types and helpers for the boot-time memory preload
//            sequencer (state encoding, state decode helpers).
// Revision : 1.0 - initial release
// ============================================================================
package mem_preload_ctrl_pkg;

    // Sequencer states. CHECK and ERR are only reachable when the checksum
    // option is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        LOAD_D = 3'd2,
        CHECK  = 3'd3,
        HOLD   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } preload_state_t;

    // States in which the stream port accepts a word.
    function automatic logic state_accepts(input preload_state_t s);
        return (s == LOAD_I) || (s == LOAD_D) || (s == CHECK);
    endfunction

    // States that count as "load in progress".
    function automatic logic state_busy(input preload_state_t s);
        return (s == LOAD_I) || (s == LOAD_D) || (s == CHECK) || (s == HOLD);
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : mem_preload_ctrl_pkg
`default_nettype wire

// File: rtl/mem_preload_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_preload_ctrl_if
// Brief    : Stream input, IMEM/DMEM write ports and status of the preload
//            sequencer. master = controller side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_preload_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_wdata_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic              imem_end_o;
    logic              dmem_end_o;
    logic              core_rstn_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        input  start_i, s_data_i, s_valid_i,
        output s_ready_o,
        output imem_we_o, imem_addr_o, imem_wdata_o,
        output dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output imem_end_o, dmem_end_o, core_rstn_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, s_data_i, s_valid_i,
        input  s_ready_o,
        input  imem_we_o, imem_addr_o, imem_wdata_o,
        input  dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  imem_end_o, dmem_end_o, core_rstn_o, busy_o, done_o, err_o
    );

endinterface : mem_preload_ctrl_if
`default_nettype wire

// File: rtl/mem_preload_ctrl_wr_port.sv
`default_nettype none
// ============================================================================
// Module   : mem_preload_ctrl_wr_port
// Brief    : One-cycle registered write stage for an SSRAM port. Address and
//            data are forced to zero when no write is requested so the bus
//            is quiet whenever the strobe is low.
// Revision : 1.0 - initial release
// ============================================================================
module mem_preload_ctrl_wr_port #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  wire logic              CLK,
    input  wire logic              RSTn,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] addr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic                   we_o,
    output logic [ADDR_W-1:0]      addr_o,
    output logic [DATA_W-1:0]      wdata_o
);

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Gate address/data with the request so idle cycles drive zeros.
    always_comb begin
        we_d    = we_i;
        addr_d  = we_i ? addr_i  : '0;
        wdata_d = we_i ? wdata_i : '0;
    end

    // Write request register: strobe appears the cycle after the transfer.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule : mem_preload_ctrl_wr_port
`default_nettype wire

// File: rtl/mem_preload_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_preload_ctrl
// Brief    : Boot-time sequencer. Streams IMEM_LENGTH words into IMEM, then
//            DMEM_LENGTH words into DMEM while holding the core in reset,
//            then releases the core after RELEASE_DLY settle cycles.
//            Optional macro PRELOAD_CHECKSUM_EN adds a trailing checksum word
//            that must equal the modulo-2^DATA_W sum of all loaded words.
// Revision : 1.0 - initial release
// ============================================================================
module mem_preload_ctrl
    import mem_preload_ctrl_pkg::*;
#(
    parameter int IMEM_LENGTH = 79,
    parameter int DMEM_LENGTH = 12,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RELEASE_DLY = 4
) (
    input  wire logic          CLK,
    input  wire logic          RSTn,
    mem_preload_ctrl_if.master bus
);

    localparam int                HOLD_W    = cnt_width(RELEASE_DLY);
    localparam logic [ADDR_W-1:0] IMEM_LAST = ADDR_W'(IMEM_LENGTH - 1);
    localparam logic [ADDR_W-1:0] DMEM_LAST = ADDR_W'(DMEM_LENGTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RELEASE_DLY - 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_wr_t;

    preload_state_t    state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              imem_end_q, imem_end_d;
    logic              dmem_end_q, dmem_end_d;
`ifdef PRELOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic    s_ready;
    logic    xfer;
    logic    restart;
    mem_wr_t imem_req;
    mem_wr_t dmem_req;

    // Ready is a pure state decode so it never depends on s_valid_i.
    assign s_ready = state_accepts(state_q);
    assign xfer    = bus.s_valid_i & s_ready;

    // Next-state, counters and write requests.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        imem_end_d = imem_end_q;
        dmem_end_d = dmem_end_q;
        imem_req   = '0;
        dmem_req   = '0;
        restart    = 1'b0;
`ifdef PRELOAD_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            IDLE: restart = bus.start_i;
            LOAD_I: begin
                if (xfer) begin
                    imem_req.we    = 1'b1;
                    imem_req.addr  = cnt_q;
                    imem_req.wdata = bus.s_data_i;
`ifdef PRELOAD_CHECKSUM_EN
                    sum_d          = sum_q + bus.s_data_i;
`endif
                    if (cnt_q == IMEM_LAST) begin
                        cnt_d      = '0;
                        imem_end_d = 1'b1;
                        state_d    = LOAD_D;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            LOAD_D: begin
                if (xfer) begin
                    dmem_req.we    = 1'b1;
                    dmem_req.addr  = cnt_q;
                    dmem_req.wdata = bus.s_data_i;
`ifdef PRELOAD_CHECKSUM_EN
                    sum_d          = sum_q + bus.s_data_i;
`endif
                    if (cnt_q == DMEM_LAST) begin
                        cnt_d      = '0;
                        hold_d     = '0;
                        dmem_end_d = 1'b1;
`ifdef PRELOAD_CHECKSUM_EN
                        state_d    = CHECK;
`else
                        state_d    = HOLD;
`endif
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
`ifdef PRELOAD_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    state_d = (bus.s_data_i == sum_q) ? HOLD : ERR;
                end
            end
            ERR: restart = bus.start_i;
`endif
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: restart = bus.start_i;
            default: state_d = IDLE;
        endcase

        // A (re)start wipes all progress and returns memory ownership to
        // the loader.
        if (restart) begin
            state_d    = LOAD_I;
            cnt_d      = '0;
            hold_d     = '0;
            imem_end_d = 1'b0;
            dmem_end_d = 1'b0;
`ifdef PRELOAD_CHECKSUM_EN
            sum_d      = '0;
`endif
        end
    end

    // State and counter registers; reset aborts any load in flight.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            imem_end_q <= 1'b0;
            dmem_end_q <= 1'b0;
`ifdef PRELOAD_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            imem_end_q <= imem_end_d;
            dmem_end_q <= dmem_end_d;
`ifdef PRELOAD_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    mem_preload_ctrl_wr_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem_port (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .we_i    (imem_req.we),
        .addr_i  (imem_req.addr),
        .wdata_i (imem_req.wdata),
        .we_o    (bus.imem_we_o),
        .addr_o  (bus.imem_addr_o),
        .wdata_o (bus.imem_wdata_o)
    );

    mem_preload_ctrl_wr_port #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_dmem_port (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .we_i    (dmem_req.we),
        .addr_i  (dmem_req.addr),
        .wdata_i (dmem_req.wdata),
        .we_o    (bus.dmem_we_o),
        .addr_o  (bus.dmem_addr_o),
        .wdata_o (bus.dmem_wdata_o)
    );

    assign bus.s_ready_o   = s_ready;
    assign bus.imem_end_o  = imem_end_q;
    assign bus.dmem_end_o  = dmem_end_q;
    assign bus.core_rstn_o = (state_q == RUN);
    assign bus.done_o      = (state_q == RUN);
    assign bus.busy_o      = state_busy(state_q);
`ifdef PRELOAD_CHECKSUM_EN
    assign bus.err_o       = (state_q == ERR);
`else
    assign bus.err_o       = 1'b0;
`endif

endmodule : mem_preload_ctrl
`default_nettype wire

// File: tb/tb_mem_preload_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_preload_ctrl
// Brief    : Self-checking bench for mem_preload_ctrl (default 79/12/4 build
//            plus a 1/1/1 instance). Honours PRELOAD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_preload_ctrl;

    localparam int IMEM_N = 79;
    localparam int DMEM_N = 12;
    localparam int DLY    = 4;
`ifdef PRELOAD_CHECKSUM_EN
    localparam int SUM_N  = 1;
`else
    localparam int SUM_N  = 0;
`endif

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    mem_preload_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bif ();
    mem_preload_ctrl_if #(.ADDR_W(1), .DATA_W(32)) sif ();

    mem_preload_ctrl #(
        .IMEM_LENGTH(IMEM_N), .DMEM_LENGTH(DMEM_N), .ADDR_W(8), .DATA_W(32), .RELEASE_DLY(DLY)
    ) u_dut (.CLK(CLK), .RSTn(RSTn), .bus(bif.master));

    mem_preload_ctrl #(
        .IMEM_LENGTH(1), .DMEM_LENGTH(1), .ADDR_W(1), .DATA_W(32), .RELEASE_DLY(1)
    ) u_small (.CLK(CLK), .RSTn(RSTn), .bus(sif.master));

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t         imem_q[$];
    wr_t         dmem_q[$];
    wr_t         s_imem_q[$];
    wr_t         s_dmem_q[$];
    int          dbl_cnt = 0;
    logic [31:0] words[$];

    // Write monitor: records every strobe seen on either memory port.
    always @(negedge CLK) begin
        if (bif.imem_we_o) imem_q.push_back('{int'(bif.imem_addr_o), bif.imem_wdata_o});
        if (bif.dmem_we_o) dmem_q.push_back('{int'(bif.dmem_addr_o), bif.dmem_wdata_o});
        if (bif.imem_we_o && bif.dmem_we_o) dbl_cnt++;
        if (sif.imem_we_o) s_imem_q.push_back('{int'(sif.imem_addr_o), sif.imem_wdata_o});
        if (sif.dmem_we_o) s_dmem_q.push_back('{int'(sif.dmem_addr_o), sif.dmem_wdata_o});
    end

    // Reference stream: IMEM words, DMEM words, optional checksum word.
    task automatic build_words(input bit rnd, input bit bad);
        logic [31:0] sum;
        logic [31:0] w;
        sum = '0;
        words.delete();
        for (int i = 0; i < IMEM_N + DMEM_N; i++) begin
            w = rnd ? $urandom : (32'h1000_0000 + i);
            words.push_back(w);
            sum = sum + w;
        end
        if (SUM_N != 0) words.push_back(bad ? sum + 32'd1 : sum);
    endtask

    task automatic issue_start();
        imem_q.delete();
        dmem_q.delete();
        dbl_cnt = 0;
        @(negedge CLK);
        bif.start_i   = 1'b1;
        bif.s_valid_i = 1'b0;
        @(negedge CLK);
        bif.start_i   = 1'b0;
    endtask

    // Feed words[] to the main DUT. mode 0: continuous, 1: alternating,
    // 2: random valid plus random ignored start pulses while busy.
    task automatic stream_load(input int mode, input int stop_after, input bit stop_on_err,
                               output int lat);
        int idx;
        bit drv;
        bit rdy;
        idx = 0; drv = 1'b0; rdy = 1'b0; lat = 0;
        forever begin
            if (drv && rdy) idx++;
            if (stop_after > 0 && idx >= stop_after) break;
            if (bif.core_rstn_o) break;
            if (stop_on_err && bif.err_o) break;
            if (lat > 3000) begin
                checks++; errors++;
                $display("FAIL load_timeout: consumed %0d of %0d words", idx, words.size());
                break;
            end
            case (mode)
                1:       drv = (lat % 2 == 0);
                2:       drv = ($urandom_range(0, 1) == 1);
                default: drv = 1'b1;
            endcase
            if (idx >= words.size()) drv = 1'b0;
            bif.s_valid_i = drv;
            bif.s_data_i  = drv ? words[idx] : $urandom;
            bif.start_i   = (mode == 2) && bif.busy_o && ($urandom_range(0, 7) == 0);
            #1;
            if (mode == 1 && bif.busy_o && !bif.imem_end_o) begin
                checks++;
                if (bif.s_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_vs_valid: s_ready=%b with s_valid=%b in IMEM load, expected 1",
                             bif.s_ready_o, drv);
                end
            end
            rdy = bif.s_ready_o;
            @(negedge CLK);
            lat++;
        end
        bif.s_valid_i = 1'b0;
        bif.start_i   = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        checks++;
        if (imem_q.size() !== IMEM_N) begin
            errors++;
            $display("FAIL %s_imem_count: got %0d expected %0d", tag, imem_q.size(), IMEM_N);
        end
        for (int i = 0; i < IMEM_N && i < imem_q.size(); i++) begin
            checks++;
            if (imem_q[i].addr !== i || imem_q[i].data !== words[i]) begin
                errors++;
                $display("FAIL %s_imem_wr[%0d]: got addr %0d data %h expected addr %0d data %h",
                         tag, i, imem_q[i].addr, imem_q[i].data, i, words[i]);
            end
        end
        checks++;
        if (dmem_q.size() !== DMEM_N) begin
            errors++;
            $display("FAIL %s_dmem_count: got %0d expected %0d", tag, dmem_q.size(), DMEM_N);
        end
        for (int i = 0; i < DMEM_N && i < dmem_q.size(); i++) begin
            checks++;
            if (dmem_q[i].addr !== i || dmem_q[i].data !== words[IMEM_N + i]) begin
                errors++;
                $display("FAIL %s_dmem_wr[%0d]: got addr %0d data %h expected addr %0d data %h",
                         tag, i, dmem_q[i].addr, dmem_q[i].data, i, words[IMEM_N + i]);
            end
        end
        checks++;
        if (dbl_cnt !== 0) begin
            errors++;
            $display("FAIL %s_one_strobe: %0d cycles with both strobes, expected 0", tag, dbl_cnt);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bif.s_ready_o, bif.imem_we_o, bif.dmem_we_o, bif.imem_end_o, bif.dmem_end_o,
             bif.core_rstn_o, bif.busy_o, bif.done_o, bif.err_o} !== 9'b0 ||
            bif.imem_addr_o !== 8'd0 || bif.dmem_addr_o !== 8'd0 ||
            bif.imem_wdata_o !== 32'd0 || bif.dmem_wdata_o !== 32'd0) begin
            errors++;
            $display("FAIL %s: flags rdy/iwe/dwe/iend/dend/rstn/busy/done/err=%b%b%b%b%b%b%b%b%b expected all 0",
                     tag, bif.s_ready_o, bif.imem_we_o, bif.dmem_we_o, bif.imem_end_o,
                     bif.dmem_end_o, bif.core_rstn_o, bif.busy_o, bif.done_o, bif.err_o);
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset_outputs");
        checks++;
        if ({sif.s_ready_o, sif.imem_we_o, sif.dmem_we_o, sif.core_rstn_o, sif.busy_o,
             sif.done_o, sif.err_o, sif.imem_end_o, sif.dmem_end_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_small: rstn=%b busy=%b rdy=%b expected 0",
                     sif.core_rstn_o, sif.busy_o, sif.s_ready_o);
        end
        RSTn = 1'b1;
        // Valid outside a load must be ignored.
        bif.s_valid_i = 1'b1;
        bif.s_data_i  = 32'hDEAD_BEEF;
        repeat (3) @(negedge CLK);
        bif.s_valid_i = 1'b0;
        checks++;
        if (imem_q.size() !== 0 || dmem_q.size() !== 0 || bif.busy_o !== 1'b0 || bif.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_valid: writes %0d/%0d busy=%b rdy=%b expected 0/0 0 0",
                     imem_q.size(), dmem_q.size(), bif.busy_o, bif.s_ready_o);
        end
    endtask

    task automatic test_full_load();
        int lat;
        int ni;
        int nd;
        build_words(1'b0, 1'b0);
        issue_start();
        stream_load(0, 0, 1'b0, lat);
        checks++;
        if (lat !== IMEM_N + DMEM_N + SUM_N + DLY) begin
            errors++;
            $display("FAIL full_latency: core released after %0d cycles expected %0d",
                     lat, IMEM_N + DMEM_N + SUM_N + DLY);
        end
        check_writes("full");
        checks++;
        if ({bif.core_rstn_o, bif.done_o, bif.busy_o, bif.s_ready_o, bif.imem_end_o,
             bif.dmem_end_o, bif.err_o} !== 7'b1100110) begin
            errors++;
            $display("FAIL run_state: rstn/done/busy/rdy/iend/dend/err=%b%b%b%b%b%b%b expected 1100110",
                     bif.core_rstn_o, bif.done_o, bif.busy_o, bif.s_ready_o, bif.imem_end_o,
                     bif.dmem_end_o, bif.err_o);
        end
        ni = imem_q.size();
        nd = dmem_q.size();
        bif.s_valid_i = 1'b1;
        bif.s_data_i  = $urandom;
        repeat (5) @(negedge CLK);
        bif.s_valid_i = 1'b0;
        checks++;
        if (imem_q.size() !== ni || dmem_q.size() !== nd || bif.core_rstn_o !== 1'b1) begin
            errors++;
            $display("FAIL run_ignores_valid: writes %0d/%0d rstn=%b expected %0d/%0d 1",
                     imem_q.size(), dmem_q.size(), bif.core_rstn_o, ni, nd);
        end
    endtask

    task automatic test_restart_in_run();
        int lat;
        build_words(1'b1, 1'b0);
        issue_start();
        checks++;
        if ({bif.core_rstn_o, bif.done_o, bif.imem_end_o, bif.dmem_end_o, bif.busy_o,
             bif.s_ready_o} !== 6'b000011) begin
            errors++;
            $display("FAIL restart_from_run: rstn/done/iend/dend/busy/rdy=%b%b%b%b%b%b expected 000011",
                     bif.core_rstn_o, bif.done_o, bif.imem_end_o, bif.dmem_end_o,
                     bif.busy_o, bif.s_ready_o);
        end
        stream_load(1, 0, 1'b0, lat);
        checks++;
        if (bif.core_rstn_o !== 1'b1) begin
            errors++;
            $display("FAIL toggle_release: rstn=%b expected 1", bif.core_rstn_o);
        end
        check_writes("toggle");
    endtask

    task automatic test_random_gaps();
        int lat;
        build_words(1'b1, 1'b0);
        issue_start();
        stream_load(2, 0, 1'b0, lat);
        checks++;
        if (bif.core_rstn_o !== 1'b1 || bif.done_o !== 1'b1) begin
            errors++;
            $display("FAIL gaps_release: rstn=%b done=%b expected 1 1", bif.core_rstn_o, bif.done_o);
        end
        check_writes("gaps");
    endtask

    task automatic test_reset_mid_load();
        int lat;
        build_words(1'b1, 1'b0);
        issue_start();
        stream_load(2, IMEM_N + 6, 1'b0, lat);
        #2 RSTn = 1'b0;
        #1 check_all_zero("async_reset_mid_load");
        @(negedge CLK);
        RSTn = 1'b1;
        build_words(1'b1, 1'b0);
        issue_start();
        stream_load(0, 0, 1'b0, lat);
        checks++;
        if (lat !== IMEM_N + DMEM_N + SUM_N + DLY) begin
            errors++;
            $display("FAIL reload_latency: %0d cycles expected %0d", lat, IMEM_N + DMEM_N + SUM_N + DLY);
        end
        check_writes("after_reset");
    endtask

`ifdef PRELOAD_CHECKSUM_EN
    task automatic test_checksum();
        int lat;
        build_words(1'b1, 1'b1);
        issue_start();
        stream_load(0, 0, 1'b1, lat);
        checks++;
        if (lat !== IMEM_N + DMEM_N + 1) begin
            errors++;
            $display("FAIL bad_sum_latency: err after %0d cycles expected %0d", lat, IMEM_N + DMEM_N + 1);
        end
        bif.s_valid_i = 1'b1;
        repeat (3) @(negedge CLK);
        bif.s_valid_i = 1'b0;
        checks++;
        if ({bif.err_o, bif.core_rstn_o, bif.s_ready_o, bif.done_o, bif.busy_o} !== 5'b10000) begin
            errors++;
            $display("FAIL err_state: err/rstn/rdy/done/busy=%b%b%b%b%b expected 10000",
                     bif.err_o, bif.core_rstn_o, bif.s_ready_o, bif.done_o, bif.busy_o);
        end
        build_words(1'b1, 1'b0);
        issue_start();
        checks++;
        if (bif.err_o !== 1'b0 || bif.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL err_recover: err=%b busy=%b expected 0 1", bif.err_o, bif.busy_o);
        end
        stream_load(0, 0, 1'b0, lat);
        checks++;
        if (lat !== IMEM_N + DMEM_N + 1 + DLY || bif.err_o !== 1'b0) begin
            errors++;
            $display("FAIL good_sum: latency %0d err=%b expected %0d 0", lat, bif.err_o, IMEM_N + DMEM_N + 1 + DLY);
        end
        check_writes("sum_recover");
    endtask
`endif

    task automatic test_small();
        logic [31:0] sw[$];
        logic [31:0] w0;
        logic [31:0] w1;
        int          idx;
        int          lat;
        bit          drv;
        bit          rdy;
        w0 = $urandom;
        w1 = $urandom;
        sw.push_back(w0);
        sw.push_back(w1);
        if (SUM_N != 0) sw.push_back(w0 + w1);
        s_imem_q.delete();
        s_dmem_q.delete();
        @(negedge CLK);
        sif.start_i = 1'b1;
        @(negedge CLK);
        sif.start_i = 1'b0;
        idx = 0; lat = 0; drv = 1'b0; rdy = 1'b0;
        while (sif.core_rstn_o !== 1'b1 && lat < 50) begin
            drv           = (idx < sw.size());
            sif.s_valid_i = drv;
            sif.s_data_i  = drv ? sw[idx] : 32'd0;
            rdy           = sif.s_ready_o;
            @(negedge CLK);
            lat++;
            if (drv && rdy) idx++;
        end
        sif.s_valid_i = 1'b0;
        checks++;
        if (lat !== 2 + SUM_N + 1) begin
            errors++;
            $display("FAIL small_latency: %0d cycles expected %0d", lat, 2 + SUM_N + 1);
        end
        checks++;
        if (s_imem_q.size() !== 1 || s_dmem_q.size() !== 1) begin
            errors++;
            $display("FAIL small_count: imem %0d dmem %0d expected 1 1", s_imem_q.size(), s_dmem_q.size());
        end else begin
            checks++;
            if (s_imem_q[0].addr !== 0 || s_imem_q[0].data !== w0 ||
                s_dmem_q[0].addr !== 0 || s_dmem_q[0].data !== w1) begin
                errors++;
                $display("FAIL small_writes: imem %0d/%h dmem %0d/%h expected 0/%h 0/%h",
                         s_imem_q[0].addr, s_imem_q[0].data, s_dmem_q[0].addr, s_dmem_q[0].data, w0, w1);
            end
        end
    endtask

    initial begin
        bif.start_i   = 1'b0;
        bif.s_valid_i = 1'b0;
        bif.s_data_i  = '0;
        sif.start_i   = 1'b0;
        sif.s_valid_i = 1'b0;
        sif.s_data_i  = '0;
        test_reset();
        test_full_load();
        test_restart_in_run();
        test_random_gaps();
        test_reset_mid_load();
`ifdef PRELOAD_CHECKSUM_EN
        test_checksum();
`endif
        test_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_preload_ctrl
`default_nettype wire

// File: doc/mem_preload_ctrl.md
Name: mem_preload_ctrl

Overview:
- Boot-time sequencer between a word-stream source (bench file reader, debug/UART bridge) and the riscv_top instruction and data SSRAM interfaces.
- Fills IMEM with exactly IMEM_LENGTH words, then DMEM with exactly DMEM_LENGTH words.
- Holds the core in reset throughout the load, then releases the core reset after a programmable settle delay.
- Replaces ad-hoc bench counters with a single synthesizable controller.

Parameters:
- IMEM_LENGTH, 79, number of instruction words to load (≥1).
- DMEM_LENGTH, 12, number of data words to load (≥1).
- ADDR_W, 8, memory word-address width; must satisfy 2^ADDR_W ≥ max(IMEM_LENGTH, DMEM_LENGTH).
- DATA_W, 32, word width.
- RELEASE_DLY, 4, cycles spent in HOLD before core reset is released (≥1).

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RSTn  in  1  asynchronous active-low reset.
- start_i  in  1  begin (or restart) a load; sampled in IDLE, RUN and ERR only.
- s_data_i  in  DATA_W  stream word.
- s_valid_i  in  1  stream word valid.
- s_ready_o  out  1  controller accepts a word this cycle.
- imem_we_o  out  1  IMEM write strobe.
- imem_addr_o  out  ADDR_W  IMEM word address.
- imem_wdata_o  out  DATA_W  IMEM write data.
- dmem_we_o  out  1  DMEM write strobe.
- dmem_addr_o  out  ADDR_W  DMEM word address.
- dmem_wdata_o  out  DATA_W  DMEM write data.
- imem_end_o  out  1  IMEM fill complete; memory interface returns to core ownership.
- dmem_end_o  out  1  DMEM fill complete; memory interface returns to core ownership.
- core_rstn_o  out  1  active-low reset to riscv_top.
- busy_o  out  1  load in progress (LOAD_I, LOAD_D, CHECK, HOLD).
- done_o  out  1  core running.
- err_o  out  1  checksum failure (see Optional Feature).

Behaviour:
- Reset (async, RSTn=0): state IDLE. All outputs 0, including core_rstn_o, s_ready_o, both *_end_o and err_o. Word counter = 0, hold counter = 0. Reset asserted mid-load aborts the load immediately; partial memory contents are not cleared.
- Handshake: a word transfers on a posedge where s_valid_i & s_ready_o. s_ready_o = 1 only in LOAD_I, LOAD_D and CHECK, and is decoded from state (no combinational path from s_valid_i). s_valid_i outside those states is ignored and nothing is consumed.
- Memory writes are registered, latency 1. A transfer at posedge k drives we=1, addr=counter value, wdata=word during cycle k+1. At most one strobe is high per cycle. Addresses count 0..LENGTH-1, with no wrap.
- IDLE: on start_i=1, go to LOAD_I; counter ← 0; core_rstn_o held 0.
- LOAD_I: each transfer increments the counter. On the transfer with counter = IMEM_LENGTH-1: counter ← 0, imem_end_o ← 1, go to LOAD_D.
- LOAD_D: same counting. On the transfer with counter = DMEM_LENGTH-1: dmem_end_o ← 1, go to CHECK if CHECKSUM is compiled in, else HOLD.
- HOLD: hold counter counts 0..RELEASE_DLY-1, then go to RUN. The last memory strobe completes before HOLD ends.
- RUN: core_rstn_o = 1, done_o = 1, busy_o = 0.
  - start_i=1 in RUN: next cycle core_rstn_o = 0, done_o = 0, both *_end_o = 0, state LOAD_I, counters cleared.
- Stream gaps (s_valid_i low) stall the load indefinitely; there is no timeout.
- Simultaneous events: start_i in LOAD_I, LOAD_D, CHECK or HOLD is ignored.
- Total load latency with continuous valid: IMEM_LENGTH + DMEM_LENGTH (+1 with CHECKSUM) + RELEASE_DLY cycles from leaving IDLE to core_rstn_o = 1.

Optional Feature:
- Macro: PRELOAD_CHECKSUM_EN.
- Defined:
  - A DATA_W-bit modulo-2^DATA_W running sum of every IMEM and DMEM word is kept; it is cleared on entry to LOAD_I.
  - CHECK accepts one extra stream word and compares it with the sum. Match → HOLD. Mismatch → ERR.
  - ERR: err_o = 1, core_rstn_o = 0, s_ready_o = 0. Left only by start_i (err_o clears, state LOAD_I) or by reset.
- Undefined: no CHECK or ERR states, no accumulator, err_o tied 0.

Decomposition:
- riscv_pkg gains:
  - typedef enum preload_state_t {IDLE, LOAD_I, LOAD_D, CHECK, HOLD, RUN, ERR};
  - typedef struct mem_wr_t {we, addr, wdata}, used for both memory ports.
- One natural sub-module: preload_wr_port, the registered write-strobe/address/data stage, instantiated twice (IMEM and DMEM).

Test Plan:
- Reset then start_i with continuous valid, words 0x1000_0000+i: 79 IMEM writes at addr 0..78, then 12 DMEM writes at addr 0..11; core_rstn_o rises exactly 79+12+4 cycles after leaving IDLE.
- s_valid_i toggling 1/0 during LOAD_I: each word written exactly once, addresses contiguous, s_ready_o never depends on s_valid_i.
- RSTn pulsed low at DMEM word 5: all outputs 0 asynchronously; new start reloads from IMEM addr 0.
- start_i during RUN: core_rstn_o = 0 next cycle, imem_end_o/dmem_end_o = 0, reload begins at addr 0.
- PRELOAD_CHECKSUM_EN, correct sum appended: reaches RUN, err_o = 0. Sum + 1 appended: err_o = 1, core_rstn_o stays 0; start_i recovers.
- IMEM_LENGTH=1, DMEM_LENGTH=1, RELEASE_DLY=1: two writes, core_rstn_o high 3 cycles after leaving IDLE.
